bcd_ssd_driver: RTL and testbench

BCD_SSD_DRIVER -- requirements
Module: bcd_ssd_driver

---
 rtl/bcd_ssd_driver.sv | 152 +++++++++++++++
 tb/tb_bcd_ssd_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bcd_ssd_driver.sv
// Binary-to-BCD converter (double-dabble, one iteration per cycle)
// driving a 4-digit multiplexed seven-segment display with blanking.
module bcd_ssd_driver #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  Anode,
  output logic [6:0]  ssd_out
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t state;
  state_t state_nx;

  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  iter;
  logic [15:0] disp;
  logic [REFRESH_BITS-1:0] cnt;

  logic [15:0] adj;
  logic [15:0] bcd_sh;
  logic [13:0] bin_sh;
  logic [13:0] sat;
  logic        last;

  assign busy = (state == CONV);
  assign last = (iter == 4'd13);
  assign sat  = (value > 14'd9999) ? 14'd9999 : value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load) state_nx = CONV;
      CONV: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Add-3 correction precedes the shift of each iteration
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_sh = {adj[14:0], bin[13]};
    bin_sh = {bin[12:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      bcd  <= '0;
      iter <= '0;
      disp <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        bin  <= sat;
        bcd  <= '0;
        iter <= '0;
      end
    end else begin
      bin  <= bin_sh;
      bcd  <= bcd_sh;
      iter <= iter + 4'd1;
      if (last) disp <= bcd_sh;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt + 1'b1;
  end

  logic [1:0] sel;
  logic [3:0] digit;
  logic       blank;
  logic [3:0] an_nx;
  logic [6:0] seg_nx;

  assign sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  always_comb begin
    digit = disp[3:0];
    blank = 1'b0;
    an_nx = 4'b1110;
    unique case (sel)
      2'd0: begin
        digit = disp[3:0];
        an_nx = 4'b1110;
      end
      2'd1: begin
        digit = disp[7:4];
        blank = (disp[15:4] == 12'd0);
        an_nx = 4'b1101;
      end
      2'd2: begin
        digit = disp[11:8];
        blank = (disp[15:8] == 8'd0);
        an_nx = 4'b1011;
      end
      2'd3: begin
        digit = disp[15:12];
        blank = (disp[15:12] == 4'd0);
        an_nx = 4'b0111;
      end
      default: ;
    endcase
  end

  always_comb begin
    seg_nx = 7'b1111111;
    unique case (digit)
      4'd0: seg_nx = 7'b1000000;
      4'd1: seg_nx = 7'b1111001;
      4'd2: seg_nx = 7'b0100100;
      4'd3: seg_nx = 7'b0110000;
      4'd4: seg_nx = 7'b0011001;
      4'd5: seg_nx = 7'b0010010;
      4'd6: seg_nx = 7'b0000010;
      4'd7: seg_nx = 7'b1111000;
      4'd8: seg_nx = 7'b0000000;
      4'd9: seg_nx = 7'b0010000;
      default: seg_nx = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Anode   <= 4'b1111;
      ssd_out <= 7'b1111111;
    end else if (blank) begin
      Anode   <= 4'b1111;
      ssd_out <= 7'b1111111;
    end else begin
      Anode   <= an_nx;
      ssd_out <= seg_nx;
    end
  end

endmodule

// File: tb/tb_bcd_ssd_driver.sv
// Scoreboard bench for bcd_ssd_driver with REFRESH_BITS=4:
// loads push expected numbers, a monitor checks busy and every scan cycle.
module tb_bcd_ssd_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [3:0]  Anode;
  logic [6:0]  ssd_out;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  bcd_ssd_driver #(.REFRESH_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .busy(busy),
    .Anode(Anode),
    .ssd_out(ssd_out)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {Anode, ssd_out} for a displayed number and a digit slot
  function automatic int expect_out(input int num, input int slot);
    int p;
    logic [3:0] an;
    p = (slot == 0) ? 1 : (slot == 1) ? 10 : (slot == 2) ? 100 : 1000;
    if (slot > 0 && num < p) return 32'h7ff;
    an = 4'b1111;
    an[slot] = 1'b0;
    return int'({an, enc((num / p) % 10)});
  endfunction

  task automatic issue(input int v);
    @(negedge clk);
    value = 14'(v);
    load = 1'b1;
    exp_q.push_back((v > 9999) ? 9999 : v);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int cyc;
    int bcnt;
    int dprev;
    int dnow;
    bit pb;
    cyc = 0; bcnt = 0; dprev = 0; dnow = 0; pb = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        cyc = 0; bcnt = 0; dprev = 0; dnow = 0; pb = 0;
        check("rst_busy", int'(busy), 0);
        check("rst_out", int'({Anode, ssd_out}), 32'h7ff);
      end else begin
        cyc++;
        if (busy) bcnt++;
        if (pb && !busy) begin
          check("busy_len", bcnt, 14);
          if (exp_q.size() == 0) check("unexpected_done", 1, 0);
          else dnow = exp_q.pop_front();
          bcnt = 0;
        end
        check("scan", int'({Anode, ssd_out}),
              expect_out(dprev, ((cyc - 1) % 16) / 4));
        dprev = dnow;
        pb = busy;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    #1 rst = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_out", int'({Anode, ssd_out}), 32'h7ff);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    issue(1234);
    repeat (30) @(negedge clk);
    issue(16383);
    repeat (30) @(negedge clk);
    issue(10000);
    repeat (30) @(negedge clk);

    issue(7);
    value = 14'd5555;
    load = 1'b1;
    repeat (14) @(negedge clk);
    load = 1'b0;
    repeat (20) @(negedge clk);

    issue(1005);
    repeat (30) @(negedge clk);

    issue(4321);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_out", int'({Anode, ssd_out}), 32'h7ff);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    issue(0);
    repeat (13) @(negedge clk);
    issue(9999);
    repeat (30) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      issue(int'($urandom_range(0, 16383)));
      if ($urandom_range(0, 1) == 1) repeat (13) @(negedge clk);
      else repeat (14 + $urandom_range(0, 20)) @(negedge clk);
    end
    repeat (30) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
